// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: key edge detect, LFSR foreplay delay, ms prescaler,
// reaction measurement. Optional best-time tracking is enabled by REACTION_BEST_EN.
module reaction_ctrl #(
    parameter int CLK_PER_MS   = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int TIMEOUT_MS   = 999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_stop,
    output logic       led,
    output logic [9:0] react_ms,
    output logic       result_valid,
    output logic       cheat,
    output logic       timeout,
    output logic [2:0] state,
    output logic [9:0] best_ms
);

    localparam int PW = $clog2(CLK_PER_MS + 1);
    localparam int TW = $clog2(MIN_DELAY_MS + 2048 + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_LIGHT   = 3'd2,
        ST_DONE    = 3'd3,
        ST_CHEAT   = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            key_start_prev;
    logic            key_stop_prev;
    logic            start_press_reg;
    logic            stop_press_reg;
    logic [15:0]     lfsr_reg;
    logic            lfsr_fb;
    logic [PW-1:0]   presc_reg;
    logic            ms_tick;
    logic [TW-1:0]   wait_cnt_reg;
    logic [TW-1:0]   target_reg;
    logic [TW-1:0]   target_new;
    logic [TW:0]     wait_inc;
    logic [9:0]      react_cnt_reg;
    logic [10:0]     react_inc;
    logic            state_change;
    logic            enter_wait;
    logic            enter_light;

    logic            led_reg, led_next;
    logic            cheat_reg, cheat_next;
    logic            timeout_reg, timeout_next;
    logic            result_valid_reg, result_valid_next;
    logic [9:0]      react_ms_reg, react_ms_next;

    // Presses are registered once more, so a press acts one clock after it is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_start_prev  <= 1'b1;
            key_stop_prev   <= 1'b1;
            start_press_reg <= 1'b0;
            stop_press_reg  <= 1'b0;
        end else begin
            start_press_reg <= key_start_prev & ~key_start;
            stop_press_reg  <= key_stop_prev & ~key_stop;
            key_start_prev  <= key_start;
            key_stop_prev   <= key_stop;
        end
    end

    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    assign ms_tick      = (presc_reg == PW'(CLK_PER_MS - 1));
    assign wait_inc     = {1'b0, wait_cnt_reg} + 1'b1;
    assign react_inc    = {1'b0, react_cnt_reg} + 1'b1;
    assign target_new   = TW'(MIN_DELAY_MS) + TW'(lfsr_reg[10:0]);
    assign state_change = (state_next != state_reg);
    assign enter_wait   = state_change && (state_next == ST_WAIT);
    assign enter_light  = state_change && (state_next == ST_LIGHT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_press_reg) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (stop_press_reg) begin
                    state_next = ST_CHEAT;
                end else if (ms_tick && (wait_inc == {1'b0, target_reg})) begin
                    state_next = ST_LIGHT;
                end
            end
            ST_LIGHT: begin
                if (stop_press_reg) begin
                    state_next = ST_DONE;
                end else if (ms_tick && (react_inc == 11'(TIMEOUT_MS))) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_CHEAT, ST_TIMEOUT: begin
                if (start_press_reg) state_next = ST_WAIT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Prescaler restarts on every state change so the first ms of LIGHT is a full ms.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg     <= '0;
            wait_cnt_reg  <= '0;
            target_reg    <= '0;
            react_cnt_reg <= '0;
        end else begin
            if (state_change || ms_tick) begin
                presc_reg <= '0;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end

            if (enter_wait) begin
                wait_cnt_reg <= '0;
                target_reg   <= target_new;
            end else if ((state_reg == ST_WAIT) && ms_tick && (wait_cnt_reg != {TW{1'b1}})) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end

            if (enter_light) begin
                react_cnt_reg <= '0;
            end else if ((state_reg == ST_LIGHT) && ms_tick && (react_cnt_reg != 10'h3FF)) begin
                react_cnt_reg <= react_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        led_next          = (state_next == ST_LIGHT);
        cheat_next        = (state_next == ST_CHEAT);
        timeout_next      = (state_next == ST_TIMEOUT);
        result_valid_next = state_change && (state_next == ST_DONE);
        react_ms_next     = react_ms_reg;
        if (state_change) begin
            case (state_next)
                ST_WAIT:    react_ms_next = '0;
                ST_DONE:    react_ms_next = react_cnt_reg;
                ST_TIMEOUT: react_ms_next = 10'(TIMEOUT_MS);
                default:    react_ms_next = react_ms_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg          <= 1'b0;
            cheat_reg        <= 1'b0;
            timeout_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
            react_ms_reg     <= '0;
        end else begin
            led_reg          <= led_next;
            cheat_reg        <= cheat_next;
            timeout_reg      <= timeout_next;
            result_valid_reg <= result_valid_next;
            react_ms_reg     <= react_ms_next;
        end
    end

    assign led          = led_reg;
    assign cheat        = cheat_reg;
    assign timeout      = timeout_reg;
    assign result_valid = result_valid_reg;
    assign react_ms     = react_ms_reg;
    assign state        = state_reg;

`ifdef REACTION_BEST_EN
    logic [9:0] best_reg;

    // Updated on the same edge that raises result_valid, so both appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_reg <= 10'd1023;
        end else if (result_valid_next && (react_ms_next < best_reg)) begin
            best_reg <= react_ms_next;
        end
    end

    assign best_ms = best_reg;
`else
    assign best_ms = 10'd0;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: stimulus queues expected state-entry records,
// a monitor compares them on every observed state change.
module tb_reaction_ctrl;

    localparam int CPM = 10;
    localparam int MIN = 4;
    localparam int TMO = 20;

    logic       clk, rst, key_start, key_stop;
    logic       led, result_valid, cheat, timeout;
    logic [9:0] react_ms, best_ms;
    logic [2:0] state;

    reaction_ctrl #(.CLK_PER_MS(CPM), .MIN_DELAY_MS(MIN), .TIMEOUT_MS(TMO)) dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key_stop(key_stop),
        .led(led), .react_ms(react_ms), .result_valid(result_valid),
        .cheat(cheat), .timeout(timeout), .state(state), .best_ms(best_ms)
    );

    typedef struct {
        logic [2:0] st;
        logic       led;
        logic       cheat;
        logic       tmo;
        logic       rv;
        logic [9:0] react;
        logic [9:0] best;
    } exp_t;

    exp_t exp_q[$];
    int   delay_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   best_exp = 1023;
    logic [15:0] lm;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle++;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) lm <= 16'hACE1;
        else     lm <= lstep(lm);
    end

    function automatic logic [9:0] best_now();
`ifdef REACTION_BEST_EN
        return 10'(best_exp);
`else
        return 10'd0;
`endif
    endfunction

    task automatic push_rec(input logic [2:0] st, input logic l, input logic c, input logic t,
                            input logic rv, input int react);
        exp_t e;
        e.st = st; e.led = l; e.cheat = c; e.tmo = t; e.rv = rv;
        e.react = 10'(react); e.best = best_now();
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_start();
        key_start = 1'b0; tick(2); key_start = 1'b1; tick(1);
    endtask

    task automatic press_stop();
        key_stop = 1'b0; tick(2); key_stop = 1'b1; tick(1);
    endtask

    // Wait until the LFSR value the DUT will sample gives a short delay, then press start.
    task automatic start_round(input bit to_light);
        int n;
        int target;
        logic [15:0] nxt;
        n = 0;
        nxt = lstep(lm);
        while (nxt[10:0] >= 11'd24 && n < 3000) begin
            tick(1);
            n++;
            nxt = lstep(lm);
        end
        if (n >= 3000) begin
            errors++; checks++;
            $display("FAIL lfsr_search got no short delay within %0d cycles required one", n);
        end
        target = MIN + int'(nxt[10:0]);
        push_rec(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        if (to_light) begin
            push_rec(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0);
            delay_q.push_back(target * CPM);
        end
        press_start();
    endtask

    task automatic wait_led();
        int n;
        n = 0;
        while (led !== 1'b1 && n < 600) begin
            tick(1);
            n++;
        end
        if (n >= 600) begin
            errors++; checks++;
            $display("FAIL led_wait got led=%0b after %0d cycles required 1", led, n);
        end
    endtask

    // Stop press whose transition edge lands d clocks after the LED-on edge.
    task automatic stop_at(input int d);
        tick(d - 2);
        press_stop();
    endtask

    task automatic done_round(input int d, input int k);
        start_round(1'b1);
        wait_led();
        if (k < best_exp) best_exp = k;
        push_rec(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, k);
        stop_at(d);
    endtask

    // Monitor: every state change consumes one expected record.
    initial begin
        logic [2:0] last_state;
        int wait_entry;
        int d;
        exp_t e;
        last_state = 3'd0;
        wait_entry = 0;
        forever begin
            @(negedge clk);
            if (state !== last_state) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got state=%0d required no change from %0d", state, last_state);
                end else begin
                    e = exp_q.pop_front();
                    if (state !== e.st || led !== e.led || cheat !== e.cheat || timeout !== e.tmo ||
                        result_valid !== e.rv || react_ms !== e.react || best_ms !== e.best) begin
                        errors++;
                        $display("FAIL state_entry got st=%0d led=%0b cheat=%0b tmo=%0b rv=%0b react=%0d best=%0d required st=%0d led=%0b cheat=%0b tmo=%0b rv=%0b react=%0d best=%0d",
                                 state, led, cheat, timeout, result_valid, react_ms, best_ms,
                                 e.st, e.led, e.cheat, e.tmo, e.rv, e.react, e.best);
                    end
                end
                if (state === 3'd1) wait_entry = cycle;
                if (state === 3'd2) begin
                    checks++;
                    if (delay_q.size() == 0) begin
                        errors++;
                        $display("FAIL led_delay got %0d cycles required no LIGHT entry", cycle - wait_entry);
                    end else begin
                        d = delay_q.pop_front();
                        if (cycle - wait_entry != d) begin
                            errors++;
                            $display("FAIL led_delay got %0d cycles required %0d", cycle - wait_entry, d);
                        end
                    end
                end
                last_state = state;
            end else if (result_valid === 1'b1) begin
                errors++; checks++;
                $display("FAIL result_valid_extra got 1 in state %0d required 0", state);
            end
        end
    end

    initial begin
        rst = 1'b1; key_start = 1'b1; key_stop = 1'b1;
        tick(3);
        checks++;
        if (state !== 3'd0 || led !== 1'b0 || react_ms !== 10'd0 || result_valid !== 1'b0 ||
            cheat !== 1'b0 || timeout !== 1'b0 || best_ms !== best_now()) begin
            errors++;
            $display("FAIL reset_values got st=%0d led=%0b react=%0d rv=%0b cheat=%0b tmo=%0b best=%0d required st=0 led=0 react=0 rv=0 cheat=0 tmo=0 best=%0d",
                     state, led, react_ms, result_valid, cheat, timeout, best_ms, best_now());
        end
        rst = 1'b0;
        tick(2);
        press_stop();
        tick(5);

        // Rounds of 12, 7, 9 ms; extra start in WAIT and stop in DONE are ignored.
        start_round(1'b1);
        press_start();
        wait_led();
        if (12 < best_exp) best_exp = 12;
        push_rec(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 12);
        stop_at(125);
        tick(4);
        done_round(75, 7);
        press_stop();
        tick(4);
        done_round(95, 9);
        tick(4);

        // Early stop: CHEAT, then a fresh start clears it.
        start_round(1'b0);
        push_rec(3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        press_stop();
        tick(60);
        press_stop();
        tick(3);

        // No response: TIMEOUT after TMO ms.
        start_round(1'b1);
        push_rec(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, TMO);
        wait_led();
        tick(TMO * CPM + 10);

        // Stop lands on the timeout tick: DONE wins with TMO-1.
        done_round(TMO * CPM, TMO - 1);
        tick(4);

        // Reset in the middle of WAIT drops everything including best.
        start_round(1'b0);
        tick(10);
        best_exp = 1023;
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(3);
        done_round(95, 9);
        tick(6);

        checks++;
        if (exp_q.size() != 0 || delay_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect got %0d records %0d delays pending required 0 0",
                     exp_q.size(), delay_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
